// File: rtl/divisor_frecuencia.sv
// -----------------------------------------------------------------------------
// divisor_frecuencia
//   Integer clock divider producing the bit-rate clock for the UART/Bluetooth
//   TX path. clk_in is divided by DIV into a near-50%-duty clk_div. A one-cycle
//   clk_in-domain strobe (tick) marks the last cycle of every clk_div period,
//   for logic that stays on clk_in.
//
//   DIV = DIV_OVERRIDE when nonzero, otherwise round(CLK_FREQ / BAUD).
//   Low phase lasts DIV - DIV/2 cycles and high phase DIV/2 cycles, so an odd
//   DIV gives a low phase that is one cycle longer.
//
// Ports
//   clk_in   in   1  system clock, all logic on its rising edge
//   reset    in   1  asynchronous, active-high reset
//   clk_div  out  1  divided clock, period DIV clk_in cycles, straight from a flop
//   tick     out  1  one-cycle pulse while the internal counter equals DIV-1
// -----------------------------------------------------------------------------
module divisor_frecuencia #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int DIV_OVERRIDE = 0
) (
  input  logic clk_in,
  input  logic reset,
  output logic clk_div,
  output logic tick
);

  localparam int DIV      = (DIV_OVERRIDE != 0) ? DIV_OVERRIDE
                                                : (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int W        = $clog2(DIV);
  localparam int LOW_CYC  = DIV - DIV / 2;

  localparam logic [W-1:0] LAST_CNT = W'(DIV - 1);
  localparam logic [W-1:0] LOW_CNT  = W'(LOW_CYC);

  // A divider of 0 or 1 has no meaningful output; refuse to elaborate it.
  generate
    if (DIV < 2) begin : g_div_check
      $error("divisor_frecuencia: DIV must be at least 2");
    end
  endgenerate

  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_nxt_s;

  // Next counter value: wrap from DIV-1 straight back to 0, no extra cycle.
  always_comb begin
    cnt_nxt_s = {W{1'b0}};
    if (cnt_r == LAST_CNT) begin
      cnt_nxt_s = {W{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + W'(1);
    end
  end

  // Counter and output flops. Both outputs are decoded from the next count so
  // that, once registered, clk_div == (cnt_r >= LOW_CNT) and tick == (cnt_r == DIV-1).
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_r   <= {W{1'b0}};
      clk_div <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      clk_div <= (cnt_nxt_s >= LOW_CNT);
      tick    <= (cnt_nxt_s == LAST_CNT);
    end
  end

endmodule

// File: tb/tb_divisor_frecuencia.sv
// -----------------------------------------------------------------------------
// tb_divisor_frecuencia
//   Directed bench for divisor_frecuencia. Five instances (DIV = 2, 4, 5, 8 and
//   the 50 MHz / 9600 default) share one clock and one reset; each task resets
//   them, then checks the instance it is about.
// -----------------------------------------------------------------------------
module tb_divisor_frecuencia;

  logic clk_in;
  logic reset;

  logic clk_div_2, tick_2;
  logic clk_div_4, tick_4;
  logic clk_div_5, tick_5;
  logic clk_div_8, tick_8;
  logic clk_div_d, tick_d;

  int tests_run;
  int tests_failed;

  divisor_frecuencia #(.DIV_OVERRIDE(2)) u_div2 (
    .clk_in(clk_in), .reset(reset), .clk_div(clk_div_2), .tick(tick_2));
  divisor_frecuencia #(.DIV_OVERRIDE(4)) u_div4 (
    .clk_in(clk_in), .reset(reset), .clk_div(clk_div_4), .tick(tick_4));
  divisor_frecuencia #(.DIV_OVERRIDE(5)) u_div5 (
    .clk_in(clk_in), .reset(reset), .clk_div(clk_div_5), .tick(tick_5));
  divisor_frecuencia #(.DIV_OVERRIDE(8)) u_div8 (
    .clk_in(clk_in), .reset(reset), .clk_div(clk_div_8), .tick(tick_8));
  divisor_frecuencia u_divd (
    .clk_in(clk_in), .reset(reset), .clk_div(clk_div_d), .tick(tick_d));

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Hold reset for n rising edges, release it on a falling edge.
  task automatic do_reset(input int n);
    @(negedge clk_in);
    reset = 1'b1;
    repeat (n) @(posedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
    #1;
  endtask

  // Advance one rising edge and sample just after it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    do_reset(3);
    tests_run++;
    if ({clk_div_2, tick_2, clk_div_4, tick_4, clk_div_5, tick_5,
         clk_div_8, tick_8, clk_div_d, tick_d} !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_state: outputs=%b expected all zero",
               {clk_div_2, tick_2, clk_div_4, tick_4, clk_div_5, tick_5,
                clk_div_8, tick_8, clk_div_d, tick_d});
    end
  endtask

  // DIV=4: sample 0 is right after release, sample k after the k-th edge.
  task automatic test_div4();
    logic exp_c[12];
    logic exp_t[12];
    exp_c = '{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b1,1'b1};
    exp_t = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1};
    do_reset(3);
    for (int s = 0; s < 12; s++) begin
      if (s > 0) step();
      tests_run++;
      if (clk_div_4 !== exp_c[s] || tick_4 !== exp_t[s]) begin
        tests_failed++;
        $display("FAIL div4 s=%0d: clk_div=%b tick=%b expected clk_div=%b tick=%b",
                 s, clk_div_4, tick_4, exp_c[s], exp_t[s]);
      end
    end
  endtask

  // DIV=5: low 3 cycles, high 2, tick on the last high cycle.
  task automatic test_div5();
    logic exp_c[15];
    logic exp_t[15];
    exp_c = '{1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b1,
              1'b0,1'b0,1'b0,1'b1,1'b1};
    exp_t = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,
              1'b0,1'b0,1'b0,1'b0,1'b1};
    do_reset(2);
    for (int s = 0; s < 15; s++) begin
      if (s > 0) step();
      tests_run++;
      if (clk_div_5 !== exp_c[s] || tick_5 !== exp_t[s]) begin
        tests_failed++;
        $display("FAIL div5 s=%0d: clk_div=%b tick=%b expected clk_div=%b tick=%b",
                 s, clk_div_5, tick_5, exp_c[s], exp_t[s]);
      end
    end
  endtask

  // DIV=2: clk_div toggles every edge, tick follows it.
  task automatic test_div2();
    logic exp_v[8];
    exp_v = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1};
    do_reset(2);
    for (int s = 0; s < 8; s++) begin
      if (s > 0) step();
      tests_run++;
      if (clk_div_2 !== exp_v[s] || tick_2 !== exp_v[s]) begin
        tests_failed++;
        $display("FAIL div2 s=%0d: clk_div=%b tick=%b expected both %b",
                 s, clk_div_2, tick_2, exp_v[s]);
      end
    end
  endtask

  // DIV=8: asynchronous reset between edges while cnt=6 (high phase).
  task automatic test_async_reset();
    do_reset(2);
    repeat (6) step();
    tests_run++;
    if (clk_div_8 !== 1'b1 || tick_8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_pre: clk_div=%b tick=%b expected clk_div=1 tick=0",
               clk_div_8, tick_8);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (clk_div_8 !== 1'b0 || tick_8 !== 1'b0 || u_div8.cnt_r !== 3'd0) begin
      tests_failed++;
      $display("FAIL async_now: clk_div=%b tick=%b cnt=%0d expected 0 0 0",
               clk_div_8, tick_8, u_div8.cnt_r);
    end
    @(negedge clk_in);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      tests_run++;
      if (clk_div_8 !== ((k >= 4) ? 1'b1 : 1'b0)) begin
        tests_failed++;
        $display("FAIL async_rise k=%0d: clk_div=%b expected %b",
                 k, clk_div_8, (k >= 4) ? 1'b1 : 1'b0);
      end
    end
  endtask

  // Default parameters: DIV=5208, measure edge numbers of rises and falls.
  task automatic test_default();
    int rise_e[4];
    int fall_e[4];
    int n_rise;
    int n_fall;
    int n_tick;
    logic prev;
    n_rise = 0;
    n_fall = 0;
    n_tick = 0;
    do_reset(2);
    prev = clk_div_d;
    for (int k = 1; k <= 4 * 5208; k++) begin
      step();
      if (clk_div_d === 1'b1 && prev === 1'b0) begin
        if (n_rise < 4) rise_e[n_rise] = k;
        n_rise++;
      end
      if (clk_div_d === 1'b0 && prev === 1'b1) begin
        if (n_fall < 4) fall_e[n_fall] = k;
        n_fall++;
      end
      if (tick_d === 1'b1) n_tick++;
      prev = clk_div_d;
    end
    tests_run++;
    if (n_rise !== 4 || n_fall !== 4 || n_tick !== 4) begin
      tests_failed++;
      $display("FAIL default_counts: rises=%0d falls=%0d ticks=%0d expected 4 4 4",
               n_rise, n_fall, n_tick);
    end else begin
      tests_run++;
      if (rise_e[0] !== 2604) begin
        tests_failed++;
        $display("FAIL default_first_rise: edge=%0d expected 2604", rise_e[0]);
      end
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (rise_e[i+1] - rise_e[i] !== 5208 || fall_e[i] - rise_e[i] !== 2604 ||
            rise_e[i+1] - fall_e[i] !== 2604) begin
          tests_failed++;
          $display("FAIL default_period %0d: period=%0d high=%0d low=%0d expected 5208 2604 2604",
                   i, rise_e[i+1] - rise_e[i], fall_e[i] - rise_e[i],
                   rise_e[i+1] - fall_e[i]);
        end
      end
    end
  endtask

  // Reset held for 100 cycles: nothing moves.
  task automatic test_reset_hold();
    @(negedge clk_in);
    reset = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      tests_run++;
      if ({clk_div_2, tick_2, clk_div_4, tick_4, clk_div_5, tick_5,
           clk_div_8, tick_8, clk_div_d, tick_d} !== 10'b0 ||
          u_div8.cnt_r !== 3'd0 || u_div5.cnt_r !== 3'd0) begin
        tests_failed++;
        $display("FAIL reset_hold k=%0d: outputs=%b cnt8=%0d cnt5=%0d expected zeros",
                 k, {clk_div_2, tick_2, clk_div_4, tick_4, clk_div_5, tick_5,
                     clk_div_8, tick_8, clk_div_d, tick_d},
                 u_div8.cnt_r, u_div5.cnt_r);
      end
    end
    @(negedge clk_in);
    reset = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    test_reset();
    test_div4();
    test_div5();
    test_div2();
    test_async_reset();
    test_default();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
